// File: rtl/fpu_pkg.sv
// Shared IEEE-754 single-precision constants, the result-entry type and the NaN
// classifier used by the add/sub issuer and its result FIFO.
package fpu_pkg;

    localparam int WIDTH     = 32;
    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;

    localparam logic [WIDTH-1:0] CAN_NAN = 32'h7FC0_0000;

    // One result FIFO entry: the value and its precomputed NaN flag.
    typedef struct packed {
        logic             nan;
        logic [WIDTH-1:0] r;
    } result_t;

    function automatic logic is_nan(input logic [WIDTH-1:0] x);
        return (x[WIDTH-2 -: EXP_BITS] == '1) && (x[MANT_BITS-1:0] != '0);
    endfunction

endpackage

// File: rtl/fpu_addsub_issuer_if.sv
// Bundles the upstream operand channel, the add_sub_main core port and the
// downstream result channel. master = issuer side, slave = surrounding system.
interface fpu_addsub_issuer_if
    import fpu_pkg::*;
#(
    parameter int W = WIDTH
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_op;

    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_op;
    logic [W-1:0] core_r;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic         out_nan;
    logic         nan_err;

    modport master (
        input  in_valid, in_a, in_b, in_op, core_r, out_ready,
        output in_ready, core_a, core_b, core_op, out_valid, out_r, out_nan, nan_err
    );

    modport slave (
        output in_valid, in_a, in_b, in_op, core_r, out_ready,
        input  in_ready, core_a, core_b, core_op, out_valid, out_r, out_nan, nan_err
    );

endinterface

// File: rtl/fpu_result_fifo.sv
// First-word fall-through result FIFO with modulo-DEPTH pointers (any DEPTH) and an
// occupancy count; the issuer's credit logic guarantees it is never pushed when full.
module fpu_result_fifo #(
    parameter  int W     = 33,
    parameter  int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    push_never_full: assert property (@(posedge clk) disable iff (!arst_n) push |-> !full);

endmodule

// File: rtl/fpu_addsub_issuer.sv
// Issues operand pairs into the fixed-latency add_sub_main core, tracks them with a
// LAT-deep shift register and collects results into a credit-guarded in-order FIFO.
module fpu_addsub_issuer
    import fpu_pkg::*;
#(
    parameter int LAT   = 6,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                arst_n,
    fpu_addsub_issuer_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [WIDTH-1:0] core_a_q;
    logic [WIDTH-1:0] core_b_q;
    logic             core_op_q;
    logic [LAT-1:0]   sr;
    logic [LAT-1:0]   nanq;
    logic             nan_err_q;

    logic             fire;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    result_t          push_data;
    result_t          head;

    // Credit uses registered state only, so in_ready never depends on out_ready.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        occupancy = '0;
        push_data = '0;
        occupancy = OCC_W'(fifo_count) + OCC_W'($countones(sr));
        push_data = '{nan: is_nan(bus.core_r), r: bus.core_r};
    end

    assign bus.in_ready = arst_n && (occupancy < OCC_W'(DEPTH));
    assign fire         = bus.in_valid && bus.in_ready;
    assign push         = sr[LAT-1];
    assign pop          = !fifo_empty && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            core_a_q  <= '0;
            core_b_q  <= '0;
            core_op_q <= 1'b0;
            sr        <= '0;
            nanq      <= '0;
            nan_err_q <= 1'b0;
        end else begin
            if (fire) begin
                core_a_q  <= bus.in_a;
                core_b_q  <= bus.in_b;
                core_op_q <= bus.in_op;
            end
            sr   <= (sr << 1) | LAT'(fire);
            nanq <= (nanq << 1) | LAT'(fire && (is_nan(bus.in_a) || is_nan(bus.in_b)));
            if (sr[LAT-1] && nanq[LAT-1] && (bus.core_r != CAN_NAN)) begin
                nan_err_q <= 1'b1;
            end
        end
    end

    fpu_result_fifo #(
        .W     ($bits(result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.core_a    = core_a_q;
    assign bus.core_b    = core_b_q;
    assign bus.core_op   = core_op_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_r     = fifo_empty ? '0 : head.r;
    assign bus.out_nan   = !fifo_empty && head.nan;
    assign bus.nan_err   = nan_err_q;

endmodule

// File: tb/tb_fpu_addsub_issuer.sv
// Randomized bench for fpu_addsub_issuer: a real-arithmetic core model feeds core_r,
// and a queue of issued-but-unpopped results predicts order, values and credit.
module tb_fpu_addsub_issuer;
    import fpu_pkg::*;

    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] r;
        logic        nan;
    } exp_t;

    logic        clk       = 1'b0;
    logic        arst_n    = 1'b0;
    logic        force_bad = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    logic [31:0] core_pipe [LAT-1];

    fpu_addsub_issuer_if #(.W(WIDTH)) bus ();

    fpu_addsub_issuer #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic nan_bits(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) d = {x[31], 63'd0};
        else                  d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] to_single(input real v);
        logic [63:0] d;
        d = $realtobits(v);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Stand-in for add_sub_main: real arithmetic, canonical NaN unless forced bad.
    function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic op);
        if (nan_bits(a) || nan_bits(b)) return force_bad ? 32'h7FC0_0001 : 32'h7FC0_0000;
        return to_single(op ? to_real(a) - to_real(b) : to_real(a) + to_real(b));
    endfunction

    function automatic logic [31:0] rand_norm();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // The issue edge is the first of the LAT edges, so the core adds LAT-1 register stages.
    always @(posedge clk) begin
        core_pipe[0] <= core_model(bus.core_a, bus.core_b, bus.core_op);
        for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign bus.core_r = core_pipe[LAT-2];

    // Drives one cycle at the falling edge and books what the next rising edge will do.
    task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic rdy,
                        output logic fired, output logic popped,
                        output logic [31:0] got_r, output logic got_nan,
                        output exp_t want, output logic have_want,
                        output logic got_ready, output logic want_ready);
        logic [31:0] r;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.out_ready = rdy;
        got_ready  = bus.in_ready;
        want_ready = (exp_q.size() < DEPTH);
        fired      = v && bus.in_ready;
        popped     = bus.out_valid && rdy;
        got_r      = bus.out_r;
        got_nan    = bus.out_nan;
        have_want  = 1'b0;
        want       = '{r: 32'd0, nan: 1'b0};
        if (popped && exp_q.size() != 0) begin
            want      = exp_q.pop_front();
            have_want = 1'b1;
        end
        if (fired) begin
            r = core_model(a, b, op);
            exp_q.push_back('{r: r, nan: nan_bits(r)});
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b0;
        arst_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_r !== 32'd0 || bus.out_nan !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out got valid=%b r=%h nan=%b want 0/0/0", bus.out_valid, bus.out_r, bus.out_nan);
        end
        vectors++;
        if (bus.core_a !== 32'd0 || bus.core_b !== 32'd0 || bus.core_op !== 1'b0 || bus.nan_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_core got a=%h b=%h op=%b err=%b want all 0", bus.core_a, bus.core_b, bus.core_op, bus.nan_err);
        end
        arst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_single_add();
        int edges = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h3F80_0000;
        bus.in_b      = 32'h4000_0000;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_in_ready got=%b want=1", bus.in_ready);
        end
        while (edges < 4 * LAT) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) break;
        end
        vectors++;
        if (edges != LAT + 1) begin
            miscompares++; $display("FAIL single_latency got=%0d edges want=%0d", edges, LAT + 1);
        end
        vectors++;
        if (bus.out_r !== 32'h4040_0000 || bus.out_nan !== 1'b0) begin
            miscompares++;
            $display("FAIL single_result got r=%h nan=%b want r=40400000 nan=0", bus.out_r, bus.out_nan);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_pop got out_valid=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic fired, popped, got_nan, have, gr, wr, v;
        logic [31:0] got_r;
        exp_t want;
        int fires = 0, pops = 0, dropped = 0;
        for (int cyc = 0; cyc < 200 && (fires < 20 || pops < 20); cyc++) begin
            v = (fires < 20);
            tick(v, rand_norm(), rand_norm(), 1'($urandom_range(0, 1)), 1'b1,
                 fired, popped, got_r, got_nan, want, have, gr, wr);
            if (v && !fired) dropped++;
            if (fired) fires++;
            if (popped) begin
                pops++;
                vectors++;
                if (!have || got_r !== want.r || got_nan !== want.nan) begin
                    miscompares++;
                    $display("FAIL b2b_result got r=%h nan=%b want r=%h nan=%b", got_r, got_nan, want.r, want.nan);
                end
            end
        end
        vectors++;
        if (dropped != 0) begin
            miscompares++; $display("FAIL b2b_in_ready got %0d stalled cycles want 0", dropped);
        end
        vectors++;
        if (pops != 20) begin
            miscompares++; $display("FAIL b2b_count got=%0d want=20", pops);
        end
    endtask

    task automatic test_backpressure();
        logic fired, popped, got_nan, have, gr, wr;
        logic [31:0] got_r;
        exp_t want;
        int fires = 0, pops = 0, credit_bad = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick(1'b1, rand_norm(), rand_norm(), 1'($urandom_range(0, 1)), 1'b0,
                 fired, popped, got_r, got_nan, want, have, gr, wr);
            if (gr !== wr) credit_bad++;
            if (fired) fires++;
        end
        vectors++;
        if (fires != DEPTH) begin
            miscompares++; $display("FAIL bp_accepted got=%0d want=%0d", fires, DEPTH);
        end
        vectors++;
        if (credit_bad != 0) begin
            miscompares++; $display("FAIL bp_credit got %0d wrong in_ready cycles want 0", credit_bad);
        end
        for (int cyc = 0; cyc < 60 && exp_q.size() != 0; cyc++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
            if (popped) begin
                pops++;
                vectors++;
                if (!have || got_r !== want.r || got_nan !== want.nan) begin
                    miscompares++;
                    $display("FAIL bp_result got r=%h nan=%b want r=%h nan=%b", got_r, got_nan, want.r, want.nan);
                end
            end
        end
        vectors++;
        if (pops != DEPTH) begin
            miscompares++; $display("FAIL bp_drained got=%0d want=%0d", pops, DEPTH);
        end
        tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
        vectors++;
        if (gr !== 1'b1 || popped) begin
            miscompares++; $display("FAIL bp_after got in_ready=%b extra_pop=%b want 1/0", gr, popped);
        end
    endtask

    task automatic test_random();
        logic fired, popped, got_nan, have, gr, wr;
        logic [31:0] got_r, a;
        exp_t want;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h7FA0_0000 : rand_norm();
            if (cyc < 300)
                tick(1'($urandom_range(0, 9) < 7), a, rand_norm(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) < 6), fired, popped, got_r, got_nan, want, have, gr, wr);
            else
                tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
            vectors++;
            if (gr !== wr) begin
                miscompares++; $display("FAIL rand_credit cyc=%0d got in_ready=%b want=%b", cyc, gr, wr);
            end
            if (popped) begin
                vectors++;
                if (!have || got_r !== want.r || got_nan !== want.nan) begin
                    miscompares++;
                    $display("FAIL rand_result got r=%h nan=%b want r=%h nan=%b", got_r, got_nan, want.r, want.nan);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || bus.nan_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_end got left=%0d nan_err=%b want 0/0", exp_q.size(), bus.nan_err);
        end
    endtask

    task automatic test_nan();
        logic fired, popped, got_nan, have, gr, wr;
        logic [31:0] got_r;
        exp_t want;
        int pops = 0;
        for (int pass = 0; pass < 2; pass++) begin
            force_bad = (pass == 1);
            tick(1'b1, (pass == 0) ? 32'h7F80_0001 : rand_norm(),
                 (pass == 0) ? rand_norm() : 32'hFFC1_2345, 1'(pass), 1'b1,
                 fired, popped, got_r, got_nan, want, have, gr, wr);
            pops = 0;
            for (int cyc = 0; cyc < 30 && pops == 0; cyc++) begin
                tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
                if (popped) pops++;
            end
            vectors++;
            if (pops != 1 || got_r !== (pass == 0 ? 32'h7FC0_0000 : 32'h7FC0_0001) || got_nan !== 1'b1) begin
                miscompares++;
                $display("FAIL nan_result pass=%0d got pops=%0d r=%h nan=%b", pass, pops, got_r, got_nan);
            end
            vectors++;
            if (bus.nan_err !== 1'(pass)) begin
                miscompares++; $display("FAIL nan_err pass=%0d got=%b want=%0d", pass, bus.nan_err, pass);
            end
        end
        force_bad = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++)
            tick(1'(cyc < 3), rand_norm(), rand_norm(), 1'b0, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
        vectors++;
        if (bus.nan_err !== 1'b1 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL nan_err_sticky got=%b left=%0d want 1/0", bus.nan_err, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic fired, popped, got_nan, have, gr, wr;
        logic [31:0] got_r;
        exp_t want;
        int stale = 0, pops = 0;
        for (int cyc = 0; cyc < 8; cyc++)
            tick(1'(cyc < 5), rand_norm(), rand_norm(), 1'b0, 1'b0, fired, popped, got_r, got_nan, want, have, gr, wr);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_before got out_valid=%b in_ready=%b want 1/1", bus.out_valid, bus.in_ready);
        end
        arst_n       = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.nan_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got out_valid=%b in_ready=%b nan_err=%b want 0/0/0",
                     bus.out_valid, bus.in_ready, bus.nan_err);
        end
        @(negedge clk);
        arst_n = 1'b1;
        exp_q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
            if (popped) stale++;
        end
        vectors++;
        if (stale != 0 || gr !== 1'b1) begin
            miscompares++; $display("FAIL mid_after got stale=%0d in_ready=%b want 0/1", stale, gr);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick(1'(cyc == 0), rand_norm(), rand_norm(), 1'b1, 1'b1, fired, popped, got_r, got_nan, want, have, gr, wr);
            if (popped) begin
                pops++;
                vectors++;
                if (!have || got_r !== want.r || got_nan !== want.nan) begin
                    miscompares++;
                    $display("FAIL mid_result got r=%h nan=%b want r=%h nan=%b", got_r, got_nan, want.r, want.nan);
                end
            end
        end
        vectors++;
        if (pops != 1) begin
            miscompares++; $display("FAIL mid_count got=%0d want=1", pops);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_nan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
